kamacore_wb_arbiter: RTL and testbench
======================================

Name: kamacore_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters: the in-order writeback stage and the long-latency unit (mul/div, later load-return).
- Pipeline writes always have priority. Long-latency results are buffered in a small FIFO and drain into free write slots.
- A starvation counter forces a one-cycle pipeline stall so that buffered results always retire.
- Sits between kamacore_stage_wb and the register file.

Parameters:
CPU_WIDTH, 32, data width of a register write
REG_ADDR_WIDTH, 5, register address width
FIFO_DEPTH, 4, long-latency result buffer entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles with FIFO non-empty before a forced drain

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
pipe_we  input  1  writeback stage write request
pipe_rd_a  input  REG_ADDR_WIDTH  writeback destination register
pipe_rd_data  input  CPU_WIDTH  writeback data
lu_valid  input  1  long-latency result valid
lu_ready  output  1  arbiter can accept a long-latency result
lu_rd_a  input  REG_ADDR_WIDTH  long-latency destination register
lu_data  input  CPU_WIDTH  long-latency result
stall  output  1  writeback stage must hold its current request this cycle
rf_we  output  1  register-file write enable (registered)
rf_a  output  REG_ADDR_WIDTH  register-file write address (registered)
rf_data  output  CPU_WIDTH  register-file write data (registered)
fifo_count  output  $clog2(FIFO_DEPTH)+1  buffered entries, for debug/perf

Behaviour:
- Reset (rst low, asynchronous): rf_we=0, rf_a=0, rf_data=0, FIFO empty, fifo_count=0, starve counter=0, stall=0, lu_ready=1.
- LU handshake: a transfer occurs when lu_valid && lu_ready at a rising edge.
  - lu_ready = (fifo_count < FIFO_DEPTH), derived from registered state only; no path from lu_valid.
  - Once lu_valid is raised, lu_rd_a and lu_data must stay stable until the transfer.
- Register x0 filtering:
  - An accepted LU result with lu_rd_a==0 is discarded and never enters the FIFO.
  - A pipeline request with pipe_rd_a==0 is treated as no request and leaves the slot free.
- Slot decision per cycle:
  - Pipeline write granted when pipe_we && pipe_rd_a!=0 && !stall.
  - Otherwise the FIFO head drains if the FIFO is non-empty.
  - Otherwise no write.
- Latency:
  - Granted pipeline request in cycle N -> rf_we=1 with its address/data in cycle N+1.
  - FIFO head drained in cycle N -> rf_we=1 in cycle N+1.
  - An idle slot gives rf_we=0 in N+1; rf_a/rf_data hold their previous values.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leaves the count unchanged.
  - Entries drain strictly in acceptance order.
  - No push is possible when full because lu_ready=0.
  - Ordering against pipeline writes to the same register (WAW) is the issue stage's responsibility.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not drained.
  - Clears on any drain and whenever the FIFO is empty.
  - When the count equals STARVE_LIMIT, stall=1 for exactly that cycle. The head drains; the pipeline request is ignored and must be re-presented the next cycle. The counter then clears.
- stall is combinational from the starve counter only; no dependency on the pipe_* inputs.
- Reset mid-operation: all buffered entries are lost and no rf_we is issued after the reset edge.

Optional Feature:
KAMACORE_WB_BYPASS_EN
- Defined: when the FIFO is empty, the slot is free (no granted pipeline write) and an LU transfer occurs with lu_rd_a!=0, the result is written directly. rf_we follows in N+1 and the FIFO is not touched.
- Undefined: every LU result passes through the FIFO, so the minimum transfer-to-rf_we latency is 2 cycles.

Test Plan:
- Reset, then pipe_we=1, pipe_rd_a=5, pipe_rd_data=0xDEADBEEF in cycle 1 -> rf_we=1, rf_a=5, rf_data=0xDEADBEEF in cycle 2. Asserting rst low mid-write clears rf_we immediately.
- LU transfer rd=7, data=0x12 with the pipeline idle -> rf_we for x7 at N+2 without bypass, at N+1 with KAMACORE_WB_BYPASS_EN. fifo_count peaks at 1 without bypass, stays 0 with it.
- Hold pipe_we=1 every cycle and push 4 LU results (rd 1..4) -> fifo_count reaches 4 and lu_ready=0. After 8 blocked cycles, stall=1 for one cycle and x1 is written. Repeating drains x2, x3, x4 in order.
- Pipeline continuously writes x0 while LU pushes rd=9 -> the x0 request leaves the slot free and x9 drains. rf_we is never asserted with rf_a=0.
- LU transfer with lu_rd_a=0 -> fifo_count stays 0 and no rf_we results.
- FIFO full; in the same cycle one entry drains and lu_valid=1 -> lu_ready is 0 in that cycle, so no push. The push completes the next cycle. Pointer wrap is checked over 10 pushes with data intact.

Source files
------------

// File: rtl/kamacore_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : kamacore_wb_arbiter_if
// Purpose  : Bundles the writeback-side traffic of kamacore_wb_arbiter:
//            the in-order pipeline write request, the long-latency unit
//            (LU) result handshake, the stall back-pressure, the
//            register-file write port and the debug occupancy count.
// Modports : master - requesters / register-file side (drives pipe_*, lu_*)
//            slave  - the arbiter (drives lu_ready, stall, rf_*, fifo_count)
// Revision : 1.0 - initial release
// ============================================================================
interface kamacore_wb_arbiter_if #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 4
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      pipe_we;
  logic [REG_ADDR_WIDTH-1:0] pipe_rd_a;
  logic [CPU_WIDTH-1:0]      pipe_rd_data;
  logic                      lu_valid;
  logic                      lu_ready;
  logic [REG_ADDR_WIDTH-1:0] lu_rd_a;
  logic [CPU_WIDTH-1:0]      lu_data;
  logic                      stall;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_a;
  logic [CPU_WIDTH-1:0]      rf_data;
  logic [c_CNT_W-1:0]        fifo_count;

  modport master (
    output pipe_we, pipe_rd_a, pipe_rd_data, lu_valid, lu_rd_a, lu_data,
    input  lu_ready, stall, rf_we, rf_a, rf_data, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_rd_a, pipe_rd_data, lu_valid, lu_rd_a, lu_data,
    output lu_ready, stall, rf_we, rf_a, rf_data, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/kamacore_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kamacore_wb_arbiter
// Purpose  : Owns the single register-file write port. Pipeline writes have
//            priority; long-latency results are buffered in a circular FIFO
//            and drain into free slots. A starvation counter forces a
//            one-cycle pipeline stall so buffered results always retire.
// Ports    : clk        - core clock
//            rst        - asynchronous reset, active low
//            bus        - kamacore_wb_arbiter_if.slave (pipe_*, lu_*, stall,
//                         rf_we/rf_a/rf_data registered, fifo_count)
// Options  : KAMACORE_WB_BYPASS_EN - write an LU result straight to the
//            register file when the FIFO is empty and the slot is free.
// Revision : 1.0 - initial release
// ============================================================================
module kamacore_wb_arbiter #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  kamacore_wb_arbiter_if.slave bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int c_ENT_W = REG_ADDR_WIDTH + CPU_WIDTH;

  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);
  localparam logic [c_STV_W-1:0] c_STV_ONE = c_STV_W'(1);

  // Entry layout: {destination register, data}
  logic [c_ENT_W-1:0]        r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]        r_wptr;
  logic [c_PTR_W-1:0]        r_rptr;
  logic [c_CNT_W-1:0]        r_count;
  logic [c_STV_W-1:0]        r_starve;
  logic                      r_rf_we;
  logic [REG_ADDR_WIDTH-1:0] r_rf_a;
  logic [CPU_WIDTH-1:0]      r_rf_data;

  logic                      w_stall;
  logic                      w_lu_ready;
  logic                      w_empty;
  logic                      w_pipe_grant;
  logic                      w_pop;
  logic                      w_xfer;
  logic                      w_bypass;
  logic                      w_push;
  logic [REG_ADDR_WIDTH-1:0] w_head_a;
  logic [CPU_WIDTH-1:0]      w_head_data;

  // stall and lu_ready depend on registered state only, so neither the
  // writeback stage nor the LU sees a combinational loop through us.
  assign w_stall    = (r_starve == c_STV_MAX);
  assign w_lu_ready = (r_count < c_DEPTH);
  assign w_empty    = (r_count == '0);

  // A write to x0 is architecturally a no-op, so it never claims the slot.
  assign w_pipe_grant = bus.pipe_we && (bus.pipe_rd_a != '0) && !w_stall;
  assign w_pop        = !w_pipe_grant && !w_empty;
  assign w_xfer       = bus.lu_valid && w_lu_ready;

`ifdef KAMACORE_WB_BYPASS_EN
  assign w_bypass = w_empty && !w_pipe_grant && w_xfer && (bus.lu_rd_a != '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Accepted x0 results are dropped here and never occupy an entry.
  assign w_push = w_xfer && (bus.lu_rd_a != '0) && !w_bypass;

  assign {w_head_a, w_head_data} = r_mem[r_rptr];

  // Storage needs no reset: entries are only read when r_count says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.lu_rd_a, bus.lu_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_rf_we   <= 1'b0;
      r_rf_a    <= '0;
      r_rf_data <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;

      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_ONE;
      end

      // Reaching the limit forces w_stall, which guarantees a drain that
      // cycle, so the counter never exceeds STARVE_LIMIT.
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else begin
        r_starve <= r_starve + c_STV_ONE;
      end

      if (w_pipe_grant) begin
        r_rf_we   <= 1'b1;
        r_rf_a    <= bus.pipe_rd_a;
        r_rf_data <= bus.pipe_rd_data;
      end else if (w_pop) begin
        r_rf_we   <= 1'b1;
        r_rf_a    <= w_head_a;
        r_rf_data <= w_head_data;
      end else if (w_bypass) begin
        r_rf_we   <= 1'b1;
        r_rf_a    <= bus.lu_rd_a;
        r_rf_data <= bus.lu_data;
      end else begin
        r_rf_we   <= 1'b0;
      end
    end
  end

  assign bus.lu_ready   = w_lu_ready;
  assign bus.stall      = w_stall;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_a       = r_rf_a;
  assign bus.rf_data    = r_rf_data;
  assign bus.fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_kamacore_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kamacore_wb_arbiter
// Purpose  : Self-checking bench for kamacore_wb_arbiter. A reference model
//            predicts every register-file write; predictions are queued when
//            the stimulus is driven and popped when the DUT writes.
// Options  : KAMACORE_WB_BYPASS_EN selects the bypass expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kamacore_wb_arbiter;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int FIFO_DEPTH     = 4;
  localparam int STARVE_LIMIT   = 8;

`ifdef KAMACORE_WB_BYPASS_EN
  localparam int c_LU_LAT  = 1;
  localparam int c_LU_PEAK = 0;
`else
  localparam int c_LU_LAT  = 2;
  localparam int c_LU_PEAK = 1;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } req_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst;

  kamacore_wb_arbiter_if #(
    .CPU_WIDTH      (CPU_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) bus ();

  kamacore_wb_arbiter #(
    .CPU_WIDTH      (CPU_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .STARVE_LIMIT   (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_total = 0;
  int   n_bad   = 0;
  int   cycn    = 0;
  req_t pipe_q[$];
  req_t lu_q[$];
  req_t m_fifo[$];
  wr_t  sb[$];
  int   m_stv   = 0;

  // Per-scenario observations of the DUT
  int         peak;
  int         n_stall;
  bit         saw_nrdy;
  logic [4:0] mon_a;
  int         mon_cyc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cycn);
    end
  endtask

  task automatic mon_reset(input logic [4:0] a);
    peak     = 0;
    n_stall  = 0;
    saw_nrdy = 1'b0;
    mon_a    = a;
    mon_cyc  = -1;
  endtask

  task automatic model_flush();
    pipe_q.delete();
    lu_q.delete();
    m_fifo.delete();
    sb.delete();
    m_stv = 0;
  endtask

  // One clock cycle: drive from the request queues, check at the falling
  // edge, then advance the reference model with this cycle's decision.
  task automatic cyc();
    logic        pwe, luv, m_stall, m_rdy, grant, empty, pop, xfer, byp, exp_we;
    logic [4:0]  prd, lurd;
    logic [31:0] pdat, ludat;
    req_t        h;
    wr_t         e;
    pwe   = (pipe_q.size() > 0);
    prd   = pwe ? pipe_q[0].a : 5'd0;
    pdat  = pwe ? pipe_q[0].d : 32'd0;
    luv   = (lu_q.size() > 0);
    lurd  = luv ? lu_q[0].a : 5'd0;
    ludat = luv ? lu_q[0].d : 32'd0;
    bus.pipe_we      = pwe;
    bus.pipe_rd_a    = prd;
    bus.pipe_rd_data = pdat;
    bus.lu_valid     = luv;
    bus.lu_rd_a      = lurd;
    bus.lu_data      = ludat;

    @(negedge clk);
    chk("stall", 64'(bus.stall), 64'(m_stv == STARVE_LIMIT));
    chk("lu_ready", 64'(bus.lu_ready), 64'(m_fifo.size() < FIFO_DEPTH));
    chk("fifo_count", 64'(bus.fifo_count), 64'(m_fifo.size()));
    chk("x0_write", 64'(bus.rf_we && (bus.rf_a == 5'd0)), 64'(0));
    exp_we = (sb.size() > 0) && (sb[0].cyc == cycn);
    chk("rf_we", 64'(bus.rf_we), 64'(exp_we));
    if (exp_we) begin
      e = sb.pop_front();
      chk("rf_a", 64'(bus.rf_a), 64'(e.a));
      chk("rf_data", 64'(bus.rf_data), 64'(e.d));
    end
    if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    if (!bus.lu_ready) saw_nrdy = 1'b1;
    if (bus.stall) n_stall++;
    if (bus.rf_we && (bus.rf_a == mon_a) && (mon_cyc < 0)) mon_cyc = cycn;

    m_stall = (m_stv == STARVE_LIMIT);
    m_rdy   = (m_fifo.size() < FIFO_DEPTH);
    grant   = pwe && (prd != 5'd0) && !m_stall;
    empty   = (m_fifo.size() == 0);
    pop     = !grant && !empty;
    xfer    = luv && m_rdy;
    byp     = 1'b0;
`ifdef KAMACORE_WB_BYPASS_EN
    byp     = empty && !grant && xfer && (lurd != 5'd0);
`endif
    if (grant) begin
      sb.push_back('{prd, pdat, cycn + 1});
    end else if (pop) begin
      h = m_fifo.pop_front();
      sb.push_back('{h.a, h.d, cycn + 1});
    end else if (byp) begin
      sb.push_back('{lurd, ludat, cycn + 1});
    end
    if (xfer && (lurd != 5'd0) && !byp) m_fifo.push_back('{lurd, ludat});
    m_stv = (empty || pop) ? 0 : m_stv + 1;
    if (pwe && !m_stall) void'(pipe_q.pop_front());
    if (xfer) void'(lu_q.pop_front());

    @(posedge clk);
    #1;
    cycn++;
  endtask

  task automatic settle();
    int guard;
    guard = 0;
    while ((pipe_q.size() > 0 || lu_q.size() > 0 || m_fifo.size() > 0 || sb.size() > 0)
           && guard < 400) begin
      cyc();
      guard++;
    end
    chk("settle_budget", 64'(guard < 400), 64'(1));
    cyc();
  endtask

  initial begin
    int c0;
    rst = 1'b0;
    bus.pipe_we = 1'b0; bus.pipe_rd_a = '0; bus.pipe_rd_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd_a = '0; bus.lu_data = '0;
    mon_reset(5'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_rf_we", 64'(bus.rf_we), 64'(0));
    chk("rst_rf_a", 64'(bus.rf_a), 64'(0));
    chk("rst_rf_data", 64'(bus.rf_data), 64'(0));
    chk("rst_fifo_count", 64'(bus.fifo_count), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(0));
    chk("rst_lu_ready", 64'(bus.lu_ready), 64'(1));
    @(posedge clk);
    #1;

    // Pipeline write x5 appears one cycle later
    mon_reset(5'd5);
    c0 = cycn;
    pipe_q.push_back('{5'd5, 32'hDEADBEEF});
    settle();
    chk("pipe_latency", 64'(mon_cyc - c0), 64'(1));

    // Reset asserted while a write is on the port clears it at once
    pipe_q.push_back('{5'd6, 32'h0BADF00D});
    cyc();
    chk("pre_rst_rf_we", 64'(bus.rf_we), 64'(1));
    bus.pipe_we = 1'b0; bus.lu_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_rf_we", 64'(bus.rf_we), 64'(0));
    chk("mid_rst_rf_a", 64'(bus.rf_a), 64'(0));
    model_flush();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();
    cyc();

    // Single LU result with the pipeline idle
    mon_reset(5'd7);
    c0 = cycn;
    lu_q.push_back('{5'd7, 32'h12});
    settle();
    chk("lu_latency", 64'(mon_cyc - c0), 64'(c_LU_LAT));
    chk("lu_peak", 64'(peak), 64'(c_LU_PEAK));

    // Busy pipeline: four buffered results retire only via forced stalls
    mon_reset(5'd1);
    for (int i = 0; i < 48; i++) pipe_q.push_back('{5'(10 + (i % 20)), 32'hA000_0000 + i});
    for (int i = 1; i <= 4; i++) lu_q.push_back('{5'(i), 32'h1000_0000 + i});
    settle();
    chk("starve_peak", 64'(peak), 64'(4));
    chk("starve_full_nrdy", 64'(saw_nrdy), 64'(1));
    chk("starve_stalls", 64'(n_stall), 64'(4));

    // Pipeline hammering x0 leaves the slot free for x9
    mon_reset(5'd9);
    for (int i = 0; i < 10; i++) pipe_q.push_back('{5'd0, 32'hBAD0_0000 + i});
    lu_q.push_back('{5'd9, 32'h99});
    settle();
    chk("x0_free_slot", 64'(mon_cyc >= 0), 64'(1));

    // LU result to x0 is discarded
    mon_reset(5'd0);
    lu_q.push_back('{5'd0, 32'h77});
    repeat (4) cyc();
    settle();
    chk("lu_x0_peak", 64'(peak), 64'(0));

    // Full FIFO with a pending push plus pointer wrap over ten entries
    mon_reset(5'd20);
    for (int i = 0; i < 100; i++) pipe_q.push_back('{5'(1 + (i % 9)), 32'hB000_0000 + i});
    for (int i = 0; i < 10; i++) lu_q.push_back('{5'(11 + i), 32'hC0DE_0000 + i});
    settle();
    chk("wrap_peak", 64'(peak), 64'(4));
    chk("wrap_last_seen", 64'(mon_cyc >= 0), 64'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
